// File: rtl/game_mode_pkg.sv
// Shared mode encodings, HEX display codes and PS/2 prefix bytes for game_mode_ctrl.
package game_mode_pkg;

  typedef enum logic [3:0] {
    MODE_MENU        = 4'b0000,
    MODE_INGAME      = 4'b0011,
    MODE_PAUSED      = 4'b0100,
    MODE_ENDGAME     = 4'b0101,
    MODE_LEADERBOARD = 4'b1001
  } mode_e;

  localparam logic [3:0] HEX_MENU        = 4'd0;
  localparam logic [3:0] HEX_INGAME      = 4'd1;
  localparam logic [3:0] HEX_ENDGAME     = 4'd2;
  localparam logic [3:0] HEX_PAUSED      = 4'd3;
  localparam logic [3:0] HEX_LEADERBOARD = 4'd4;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Display code for a raw state value; unknown values show as MENU.
  function automatic logic [3:0] mode_hex(input logic [3:0] mode);
    logic [3:0] hex;
    case (mode)
      MODE_MENU:        hex = HEX_MENU;
      MODE_INGAME:      hex = HEX_INGAME;
      MODE_PAUSED:      hex = HEX_PAUSED;
      MODE_ENDGAME:     hex = HEX_ENDGAME;
      MODE_LEADERBOARD: hex = HEX_LEADERBOARD;
      default:          hex = HEX_MENU;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/game_mode_ctrl_ps2_key_filter.sv
// Turns raw PS/2 bytes into one-cycle make-code events, dropping break
// sequences (F0 xx) and the E0 extended prefix.
module ps2_key_filter
  import game_mode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_data,
  input  logic       key_pressed,
  output logic       key_evt,
  output logic [7:0] key_code
);

  logic       break_r;
  logic       key_evt_r;
  logic [7:0] key_code_r;

  // Break-flag tracking and event registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      break_r    <= 1'b0;
      key_evt_r  <= 1'b0;
      key_code_r <= 8'h00;
    end else begin
      key_evt_r <= 1'b0;
      if (key_pressed) begin
        if (break_r) begin
          break_r <= 1'b0;
        end else if (key_data == BREAK_CODE) begin
          break_r <= 1'b1;
        end else if (key_data != EXT_CODE) begin
          key_evt_r  <= 1'b1;
          key_code_r <= key_data;
        end
      end
    end
  end

  assign key_evt  = key_evt_r;
  assign key_code = key_code_r;

endmodule

// File: rtl/game_mode_ctrl.sv
// Game mode FSM: menu / in-game / paused / end-game / leaderboard.
// Define GAME_LEADERBOARD_EN to route ENDGAME exits to LEADERBOARD instead of MENU.
module game_mode_ctrl
  import game_mode_pkg::*;
#(
  parameter int         NUM_LEVELS      = 4,
  parameter int         END_HOLD_CYCLES = 150000000,
  parameter logic [7:0] KEY_START       = 8'h5A,
  parameter logic [7:0] KEY_PAUSE       = 8'h4D,
  parameter logic [7:0] KEY_QUIT        = 8'h76
) (
  input  logic                          CLOCK_50,
  input  logic                          userquit,
  input  logic [7:0]                    ps2_key_data,
  input  logic                          ps2_key_pressed,
  input  logic                          gameOver,
  input  logic                          level_cleared,
  output logic                          ingameOn,
  output logic                          paused,
  output logic [3:0]                    hex0holder,
  output logic [$clog2(NUM_LEVELS):0]   level,
  output logic [3:0]                    currentModeState
);

  localparam int LW = $clog2(NUM_LEVELS) + 1;
  localparam int HW = $clog2(END_HOLD_CYCLES + 1);
  localparam logic [LW-1:0] LEVEL_LAST = LW'(NUM_LEVELS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(END_HOLD_CYCLES - 1);

`ifdef GAME_LEADERBOARD_EN
  localparam logic [3:0] END_EXIT = MODE_LEADERBOARD;
`else
  localparam logic [3:0] END_EXIT = MODE_MENU;
`endif

  logic          key_evt_s;
  logic [7:0]    key_code_s;
  logic [3:0]    state_r, state_nxt_s;
  logic [LW-1:0] level_r, level_nxt_s;
  logic [HW-1:0] hold_r, hold_nxt_s;
  logic          ingame_r, paused_r;
  logic [3:0]    hex_r;

  ps2_key_filter u_key_filter (
    .clk         (CLOCK_50),
    .rst         (userquit),
    .key_data    (ps2_key_data),
    .key_pressed (ps2_key_pressed),
    .key_evt     (key_evt_s),
    .key_code    (key_code_s)
  );

  // Next-state, level and hold-counter logic; a key event masks game inputs.
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    hold_nxt_s  = hold_r;
    case (state_r)
      MODE_MENU: begin
        if (key_evt_s && key_code_s == KEY_START) begin
          state_nxt_s = MODE_INGAME;
          level_nxt_s = {LW{1'b0}};
        end else begin
          state_nxt_s = MODE_MENU;
        end
      end
      MODE_INGAME: begin
        if (key_evt_s) begin
          if (key_code_s == KEY_PAUSE) begin
            state_nxt_s = MODE_PAUSED;
          end else if (key_code_s == KEY_QUIT) begin
            state_nxt_s = MODE_MENU;
            level_nxt_s = {LW{1'b0}};
          end else begin
            state_nxt_s = MODE_INGAME;
          end
        end else if (gameOver || (level_cleared && level_r == LEVEL_LAST)) begin
          state_nxt_s = MODE_ENDGAME;
          hold_nxt_s  = {HW{1'b0}};
        end else if (level_cleared) begin
          level_nxt_s = level_r + LW'(1'b1);
        end else begin
          state_nxt_s = MODE_INGAME;
        end
      end
      MODE_PAUSED: begin
        if (key_evt_s && key_code_s == KEY_PAUSE) begin
          state_nxt_s = MODE_INGAME;
        end else if (key_evt_s && key_code_s == KEY_QUIT) begin
          state_nxt_s = MODE_MENU;
          level_nxt_s = {LW{1'b0}};
        end else begin
          state_nxt_s = MODE_PAUSED;
        end
      end
      MODE_ENDGAME: begin
        if ((key_evt_s && key_code_s == KEY_START) || hold_r == HOLD_LAST) begin
          state_nxt_s = END_EXIT;
        end else begin
          hold_nxt_s = hold_r + HW'(1'b1);
        end
      end
      MODE_LEADERBOARD: begin
        if (key_evt_s && key_code_s == KEY_START) begin
          state_nxt_s = MODE_MENU;
        end else begin
          state_nxt_s = MODE_LEADERBOARD;
        end
      end
      default: begin
        state_nxt_s = MODE_MENU;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they move with it.
  always_ff @(posedge CLOCK_50) begin
    if (userquit) begin
      state_r  <= MODE_MENU;
      level_r  <= {LW{1'b0}};
      hold_r   <= {HW{1'b0}};
      ingame_r <= 1'b0;
      paused_r <= 1'b0;
      hex_r    <= HEX_MENU;
    end else begin
      state_r  <= state_nxt_s;
      level_r  <= level_nxt_s;
      hold_r   <= hold_nxt_s;
      ingame_r <= (state_nxt_s == MODE_INGAME);
      paused_r <= (state_nxt_s == MODE_PAUSED);
      hex_r    <= mode_hex(state_nxt_s);
    end
  end

  assign currentModeState = state_r;
  assign level            = level_r;
  assign ingameOn         = ingame_r;
  assign paused           = paused_r;
  assign hex0holder       = hex_r;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed plus randomized checks of game_mode_ctrl against a rule-level model.
module tb_game_mode_ctrl;

  localparam int NL = 2;
  localparam int EH = 10;
  localparam logic [3:0] S_MENU = 4'b0000;
  localparam logic [3:0] S_ING  = 4'b0011;
  localparam logic [3:0] S_PAU  = 4'b0100;
  localparam logic [3:0] S_END  = 4'b0101;
  localparam logic [3:0] S_LB   = 4'b1001;
`ifdef GAME_LEADERBOARD_EN
  localparam logic [3:0] S_EXIT = S_LB;
`else
  localparam logic [3:0] S_EXIT = S_MENU;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       userquit, ps2_key_pressed, gameOver, level_cleared;
  logic [7:0] ps2_key_data;
  logic       ingameOn, paused;
  logic [3:0] hex0holder, currentModeState;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_state;
  int         m_level;
  bit         m_brk;
  bit         m_evt;
  logic [7:0] m_code;
  int         m_tick  = 0;
  int         m_entry = 0;

  game_mode_ctrl #(.NUM_LEVELS(NL), .END_HOLD_CYCLES(EH)) dut (
    .CLOCK_50         (CLOCK_50),
    .userquit         (userquit),
    .ps2_key_data     (ps2_key_data),
    .ps2_key_pressed  (ps2_key_pressed),
    .gameOver         (gameOver),
    .level_cleared    (level_cleared),
    .ingameOn         (ingameOn),
    .paused           (paused),
    .hex0holder       (hex0holder),
    .level            (level),
    .currentModeState (currentModeState)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [3:0] hex_for(input logic [3:0] s);
    if (s == S_ING) return 4'd1;
    if (s == S_END) return 4'd2;
    if (s == S_PAU) return 4'd3;
    if (s == S_LB)  return 4'd4;
    return 4'd0;
  endfunction

  function automatic void enter_end();
    m_state = S_END;
    m_entry = m_tick;
  endfunction

  // One clock edge of the rules: key seen last cycle acts now, then this cycle's byte is filtered.
  function automatic void model_edge(input bit uq, input bit kp, input logic [7:0] kd,
                                     input bit go, input bit lc);
    bit start_k, pause_k, quit_k;
    m_tick++;
    if (uq) begin
      m_state = S_MENU; m_level = 0; m_brk = 0; m_evt = 0;
    end else begin
      start_k = m_evt && m_code == 8'h5A;
      pause_k = m_evt && m_code == 8'h4D;
      quit_k  = m_evt && m_code == 8'h76;
      if (m_state == S_MENU) begin
        if (start_k) begin m_state = S_ING; m_level = 0; end
      end else if (m_state == S_ING) begin
        if (pause_k) m_state = S_PAU;
        else if (quit_k) begin m_state = S_MENU; m_level = 0; end
        else if (m_evt) m_state = S_ING;
        else if (go) enter_end();
        else if (lc && m_level < NL - 1) m_level++;
        else if (lc) enter_end();
      end else if (m_state == S_PAU) begin
        if (pause_k) m_state = S_ING;
        else if (quit_k) begin m_state = S_MENU; m_level = 0; end
      end else if (m_state == S_END) begin
        if (start_k || (m_tick - m_entry) == EH) m_state = S_EXIT;
      end else if (m_state == S_LB) begin
        if (start_k) m_state = S_MENU;
      end else begin
        m_state = S_MENU;
      end
      m_evt = 0;
      if (kp) begin
        if (m_brk) m_brk = 0;
        else if (kd == 8'hF0) m_brk = 1;
        else if (kd != 8'hE0) begin m_evt = 1; m_code = kd; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit uq, input bit kp, input logic [7:0] kd, input bit go, input bit lc);
    userquit = uq; ps2_key_pressed = kp; ps2_key_data = kd; gameOver = go; level_cleared = lc;
    @(posedge CLOCK_50);
    model_edge(uq, kp, kd, go, lc);
    #1;
    chk("model", {20'h0, currentModeState, ingameOn, paused, hex0holder, level},
        {20'h0, m_state, m_state == S_ING, m_state == S_PAU, hex_for(m_state), 2'(m_level)});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [7:0] kd);
    step(1'b0, 1'b1, kd, 1'b0, 1'b0);
  endtask

  task automatic reset_and_start();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    key(8'h5A); idle();
  endtask

  initial begin
    int dwell;
    logic [7:0] codes [6];
    codes = '{8'h5A, 8'h4D, 8'h76, 8'hF0, 8'hE0, 8'h1C};

    // Reset state
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    chk("reset", {currentModeState, ingameOn, paused, hex0holder, level}, 12'h000);

    // START: two cycles from strobe to INGAME
    key(8'h5A);
    chk("start_lat1", currentModeState, S_MENU);
    idle();
    chk("start_state", currentModeState, S_ING);
    chk("start_out", {ingameOn, paused, hex0holder, level}, {1'b1, 1'b0, 4'd1, 2'd0});

    // Break sequence swallows the following byte; then PAUSE
    key(8'hF0); idle(); key(8'h5A); idle(); idle();
    chk("break_ignored", currentModeState, S_ING);
    key(8'h4D); idle();
    chk("pause_state", currentModeState, S_PAU);
    chk("pause_out", {ingameOn, paused, hex0holder}, {1'b0, 1'b1, 4'd3});

    // Game inputs ignored while paused
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("paused_ignores", {currentModeState, level}, {S_PAU, 2'd0});

    // Resume, clear both levels; last clear ends the game without wrapping
    key(8'h4D); idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("level_inc", {currentModeState, level}, {S_ING, 2'd1});
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("last_level_end", {currentModeState, level}, {S_END, 2'd1});

    // ENDGAME dwell is exactly EH cycles
    dwell = 1;
    for (int i = 0; i < 3 * EH && currentModeState == S_END; i++) begin
      idle();
      if (currentModeState == S_END) dwell++;
    end
    chk("end_dwell", dwell, EH);
    chk("end_exit", currentModeState, S_EXIT);
    key(8'h5A); idle();
    chk("after_exit_start", currentModeState, (S_EXIT == S_LB) ? S_MENU : S_ING);

    // gameOver beats level_cleared; level unchanged
    reset_and_start();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("go_priority", {currentModeState, level}, {S_END, 2'd0});

    // START in ENDGAME exits at once
    key(8'h5A); idle();
    chk("end_start_exit", currentModeState, S_EXIT);

    // Key event beats gameOver in the same cycle
    reset_and_start();
    key(8'h4D);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("key_priority", currentModeState, S_PAU);

    // userquit from PAUSED, then after a lone F0
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("uq_paused", {currentModeState, ingameOn, paused, hex0holder, level}, 12'h000);
    key(8'hF0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("uq_break", {currentModeState, ingameOn, paused, hex0holder, level}, 12'h000);
    key(8'h5A); idle();
    chk("break_cleared", currentModeState, S_ING);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] kd;
      kd = codes[$urandom_range(0, 5)];
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, kd,
           $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
